// File: rtl/seg_adder.sv
// seg_adder: multi-cycle N-bit adder/subtractor, one W-bit segment per clock
// with the inter-segment carry held in a register; start/ready/done handshake.
module seg_adder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);
    localparam int K  = N / (W > 0 ? W : 1);
    localparam int CW = K > 1 ? $clog2(K) : 1;

    if (W < 1 || W > N || N % (W > 0 ? W : 1) != 0) begin : g_bad_params
        $error("seg_adder: N must be a multiple of W with 1 <= W <= N");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [N-1:0]  a_r, b_r, work, work_nx;
    logic [CW-1:0] cnt;
    logic          carry, last, msb_cin;
    logic [W-1:0]  a_seg, b_seg;
    logic [W:0]    s;

    // Subtraction is folded in at accept time (B inverted, carry inverted),
    // so each RUN cycle is a plain W-bit add of the current segment.
    always_comb begin
        a_seg   = a_r[cnt*W +: W];
        b_seg   = b_r[cnt*W +: W];
        s       = {1'b0, a_seg} + {1'b0, b_seg} + {{W{1'b0}}, carry};
        msb_cin = a_seg[W-1] ^ b_seg[W-1] ^ s[W-1];
        work_nx = work;
        work_nx[cnt*W +: W] = s[W-1:0];
        last    = cnt == CW'(K - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r   <= a;
                    b_r   <= b ^ {N{sub}};
                    carry <= c_in ^ sub;
                    cnt   <= '0;
                    work  <= '0;
                    state <= RUN;
                end
            end else begin
                work  <= work_nx;
                carry <= s[W];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    sum   <= work_nx;
                    c_out <= s[W];
                    ovf   <= msb_cin ^ s[W];
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

    assign ready = state == IDLE;
endmodule

// File: tb/tb_seg_adder.sv
// tb_seg_adder: scoreboard bench for seg_adder at (16,4), (8,8) and (12,3);
// expected results are queued at each start and popped when done pulses.
module tb_seg_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  start = '0;
    logic [2:0]  ready, done, c_out, ovf;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [11:0] sum2;
    logic [17:0] q0[$], q1[$], q2[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    seg_adder #(.N(16), .W(4)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .ready(ready[0]), .done(done[0]), .sum(sum0), .c_out(c_out[0]), .ovf(ovf[0])
    );
    seg_adder #(.N(8), .W(8)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .ready(ready[1]), .done(done[1]), .sum(sum1), .c_out(c_out[1]), .ovf(ovf[1])
    );
    seg_adder #(.N(12), .W(3)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a[11:0]), .b(b[11:0]), .c_in(c_in),
        .ready(ready[2]), .done(done[2]), .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2])
    );

    function automatic int n_of(input int d);
        return d == 0 ? 16 : d == 1 ? 8 : 12;
    endfunction

    function automatic int k_of(input int d);
        return d == 1 ? 1 : 4;
    endfunction

    // Reference: unsigned result and carry, signed-range overflow check.
    function automatic logic [17:0] model(input int n, input logic s, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci);
        longint m, ua, ub, sa, sb, r, t;
        logic   co, ov;
        m  = longint'(1) << n;
        ua = longint'(x) & (m - 1);
        ub = longint'(y) & (m - 1);
        sa = ua >= m / 2 ? ua - m : ua;
        sb = ub >= m / 2 ? ub - m : ub;
        if (s) begin
            r  = ua - ub - longint'(ci);
            t  = sa - sb - longint'(ci);
            co = ua >= ub + longint'(ci);
        end else begin
            r  = ua + ub + longint'(ci);
            t  = sa + sb + longint'(ci);
            co = r >= m;
        end
        ov = t >= m / 2 || t < -(m / 2);
        return {ov, co, 16'(r & (m - 1))};
    endfunction

    function automatic logic [17:0] got(input int d);
        if (d == 0) return {ovf[0], c_out[0], sum0};
        if (d == 1) return {ovf[1], c_out[1], 8'h00, sum1};
        return {ovf[2], c_out[2], 4'h0, sum2};
    endfunction

    function automatic logic [17:0] pop(input int d);
        if (d == 0) return q0.pop_front();
        if (d == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    // Drive one start pulse at the current negedge; returns one negedge later.
    task automatic op(input int d, input logic s, input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input bit push);
        sub = s;
        a = x;
        b = y;
        c_in = ci;
        start[d] = 1'b1;
        if (push) begin
            if (d == 0) q0.push_back(model(n_of(d), s, x, y, ci));
            else if (d == 1) q1.push_back(model(n_of(d), s, x, y, ci));
            else q2.push_back(model(n_of(d), s, x, y, ci));
        end
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int l0, output int lat);
        lat = l0;
        while (!done[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 3'b111 || done !== 3'b000) begin
            errors++;
            $display("FAIL reset_hs: ready=%b done=%b want ready=111 done=000", ready, done);
        end
        checks++;
        if (c_out !== 3'b000 || ovf !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: c_out=%b ovf=%b want 000 000", c_out, ovf);
        end
        checks++;
        if (sum0 !== 16'h0 || sum1 !== 8'h0 || sum2 !== 12'h0) begin
            errors++;
            $display("FAIL reset_sum: %h %h %h want all zero", sum0, sum1, sum2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic        vs[5];
        logic [15:0] va[5], vb[5];
        logic        vc[5];
        logic [17:0] vw[5], want;
        int          lat;
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        va = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h0005};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
        vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vw = '{18'h00100, 18'h10000, 18'h28000, 18'h0FFFE, 18'h0FFFD};
        for (int i = 0; i < 5; i++) begin
            op(0, vs[i], va[i], vb[i], vc[i], 1'b1);
            checks++;
            if (ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_busy: ready=%b want 0", i, ready[0]);
            end
            wait_done(0, 0, lat);
            checks++;
            if (done[0] !== 1'b1 || lat != 4 || ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_latency: lat=%0d done=%b ready=%b want lat=4 done=1 ready=1",
                         i, lat, done[0], ready[0]);
            end
            want = pop(0);
            checks++;
            if (got(0) !== vw[i] || got(0) !== want) begin
                errors++;
                $display("FAIL vec%0d_result: got %h want %h (model %h)", i, got(0), vw[i], want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int          lat, nd;
        logic [17:0] want;
        op(0, 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        sub = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        c_in = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 2, lat);
        checks++;
        if (done[0] !== 1'b1 || lat != 4) begin
            errors++;
            $display("FAIL ignore_latency: lat=%0d done=%b want lat=4 done=1", lat, done[0]);
        end
        want = pop(0);
        checks++;
        if (got(0) !== 18'h02345 || got(0) !== want) begin
            errors++;
            $display("FAIL ignore_result: got %h want 02345", got(0));
        end
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        checks++;
        if (nd != 0 || ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ignore_extra_done: extra=%0d ready=%b want 0 and 1", nd, ready[0]);
        end
    endtask

    task automatic test_reset_mid;
        int          lat, nd;
        logic [17:0] want;
        op(0, 1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (done[0] !== 1'b0 || ready[0] !== 1'b1 || got(0) !== 18'h0) begin
            errors++;
            $display("FAIL abort_state: done=%b ready=%b out=%h want 0 1 00000",
                     done[0], ready[0], got(0));
        end
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d want 0", nd);
        end
        op(0, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b1);
        wait_done(0, 0, lat);
        want = pop(0);
        checks++;
        if (done[0] !== 1'b1 || lat != 4 || got(0) !== 18'h00007 || got(0) !== want) begin
            errors++;
            $display("FAIL abort_restart: lat=%0d out=%h want lat=4 out=00007", lat, got(0));
        end
        @(negedge clk);
    endtask

    // Back-to-back random operations, each new start issued in the done cycle.
    task automatic test_back_to_back(input int d, input int n);
        int          lat;
        logic [17:0] want;
        for (int i = 0; i < n; i++) begin
            op(d, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            checks++;
            if (ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_d%0d_%0d_busy: ready=%b want 0", d, i, ready[d]);
            end
            wait_done(d, 0, lat);
            checks++;
            if (done[d] !== 1'b1 || lat != k_of(d)) begin
                errors++;
                $display("FAIL b2b_d%0d_%0d_spacing: lat=%0d done=%b want lat=%0d",
                         d, i, lat, done[d], k_of(d));
            end
            want = pop(d);
            checks++;
            if (got(d) !== want) begin
                errors++;
                $display("FAIL b2b_d%0d_%0d_result: got %h want %h", d, i, got(d), want);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back(0, 12);
        test_back_to_back(1, 20);
        test_back_to_back(2, 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
